// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, 8N1 frame constants and default baud divisor.
// Used by both the transmit and receive sides.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int unsigned DATA_BITS            = 8;
  localparam logic        START_BIT            = 1'b0;
  localparam logic        STOP_BIT             = 1'b1;
  localparam int unsigned DEFAULT_CLKS_PER_BIT = 5208;

endpackage

// File: rtl/uart_tx_fifo.sv
// Transmit byte buffer. With UART_TX_FIFO_EN defined: DEPTH-entry FIFO;
// otherwise a single holding register (DEPTH unused). Writes while full are dropped.
module uart_tx_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [7:0] din,
  input  logic       pop,
  output logic [7:0] dout,
  output logic       full,
  output logic       empty
);

`ifdef UART_TX_FIFO_EN
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (PTR_W+1)'(DEPTH));
  assign empty   = (count == '0);
  // Full is judged before any same-cycle pop, so a write at full is always lost.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
`else
  logic       valid;
  logic [7:0] hold;
  logic       unused_depth;

  assign unused_depth = ^DEPTH;
  assign full  = valid;
  assign empty = !valid;
  assign dout  = hold;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid <= 1'b0;
    end else if (push && !valid) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !valid) hold <= din;
  end
`endif

endmodule

// File: rtl/uart_tx_unit.sv
// 8N1 UART transmitter with byte buffer (uart_tx_fifo); buffer depth feature
// selected by macro UART_TX_FIFO_EN (default build: single holding register).
module uart_tx_unit
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  output logic       full,
  output logic       empty,
  output logic       busy,
  output logic       tx_done,
  output logic       uart_tx
);

  localparam logic [15:0] BAUD_MAX = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_e state;
  logic [15:0] baud_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shreg;
  logic [7:0]  fifo_dout;
  logic        push;
  logic        pop;
  logic        baud_last;

  assign push      = wr_en && !reset;
  assign pop       = (state == IDLE) && !empty;
  assign baud_last = (baud_cnt == BAUD_MAX);
  assign busy      = (state != IDLE);
  assign tx_done   = (state == STOP) && baud_last;

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .din   (wr_data),
    .pop   (pop),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      uart_tx  <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          baud_cnt <= '0;
          if (!empty) begin
            state   <= START;
            shreg   <= fifo_dout;
            uart_tx <= START_BIT;
          end
        end
        START: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            uart_tx  <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              state   <= STOP;
              uart_tx <= STOP_BIT;
            end else begin
              // Shift right so the next data bit always sits at shreg[1].
              bit_idx <= bit_idx + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              uart_tx <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        STOP: begin
          if (baud_last) begin
            baud_cnt <= '0;
            state    <= IDLE;
            uart_tx  <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + 16'd1;
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          uart_tx  <= 1'b1;
        end
      endcase
    end
  end

endmodule
